score_seg_display: RTL and testbench
====================================

SCORE_SEG_DISPLAY -- requirements
Module: score_seg_display

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, meaning clk cycles per digit slot (1 kHz digit rate at 50 MHz).
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: score  input  8  binary score from the apple generator, unsigned 0..255.
REQ-005 Port: seg  output  7  segment lines {g,f,e,d,c,b,a}, active-low.
REQ-006 Port: an  output  4  digit enables, active-low; an[0] is units, an[2] is hundreds, an[3] is unused.
REQ-007 Port: busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-008 Converter FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-009 IDLE: if score != shown_score, capture score into shift register, go to LOAD; else stay in IDLE.
REQ-010 LOAD: clear the 12-bit BCD accumulator, set iteration count to 8, go to SHIFT.
REQ-011 SHIFT, one iteration per clk: add 3 to each BCD nibble that is >= 5, then shift {bcd, bin} left by 1 and decrement the count; after the 8th iteration go to DONE.
REQ-012 DONE: copy the accumulator into the displayed digit registers, set shown_score to the captured value, return to IDLE.
REQ-013 Latency: the digit registers update exactly 11 clk cycles after the edge where IDLE sees the score difference (1 LOAD + 8 SHIFT + 1 DONE + 1 register).
REQ-014 busy is high in LOAD, SHIFT and DONE, low in IDLE.
REQ-015 Score changes during a conversion are ignored mid-flight; they are picked up on the first IDLE cycle after DONE.
REQ-016 Scan: a counter 0..SCAN_DIV-1 wraps to 0; at each wrap, a 2-bit slot index advances 0->1->2->0; slot 3 is never used.
REQ-017 In slot k, an drives only bit k low, and seg shows the segment pattern of digit k.
REQ-018 an[3] is constantly 1.
REQ-019 Segment encoding covers digits 0..9; any nibble above 9 drives seg to all 1s (blank).
REQ-020 seg and an are registered; they change one clk after a slot change, never mid-slot.
REQ-021 Slot changes are glitch-free: an and seg update on the same edge.

Reset
REQ-022 While rst=0: FSM in IDLE, busy=0, shown_score=0, digit registers 0, scan counter 0, slot 0.
REQ-023 While rst=0: an=4'b1111 and seg=7'b1111111.
REQ-024 First cycle after release: slot 0 shows "0" (seg=7'b1000000, an=4'b1110).
REQ-025 Reset asserted mid-conversion aborts the conversion immediately; no partial result reaches the display.

Configuration
REQ-026 Macro SCORE_LZB_EN selects leading-zero blanking.
REQ-027 Defined: the hundreds digit blanks when it is 0.
REQ-028 Defined: the tens digit blanks when both hundreds and tens are 0.
REQ-029 Defined: a blanked digit drives seg=all 1s, and its an bit stays low for timing uniformity.
REQ-030 Undefined: all three digits always display, including leading zeros.

Structure
REQ-031 Package score_disp_pkg holds the FSM state typedef, the ten 7-bit segment constants plus SEG_BLANK, and the digit-count constant 3.
REQ-032 The converter is a sub-module, bin2bcd_seq, with ports clk, rst, start, bin[7:0], busy, done, bcd[11:0].
REQ-033 The top of score_seg_display holds the change detect, digit registers, scan counter and segment mux.

Verification
REQ-034 Release reset with score=0, SCAN_DIV=4 -> an cycles 1110,1101,1011 every 4 clk; seg=1000000 in all slots without LZB; tens and hundreds blank with LZB.
REQ-035 score 0->255 -> busy high 10 cycles; digits 2,5,5 appear exactly 11 clk after the change; seg for 5 is 0010010.
REQ-036 score 99->100 -> digits 1,0,0; with LZB no digit blanks.
REQ-037 score 7->8, then 8->9 at the 3rd SHIFT cycle -> 8 is displayed first, then a second conversion starts and displays 9; busy shows a 1-cycle low gap between the two.
REQ-038 rst pulse low during SHIFT while converting 123 -> outputs return to reset values, and after release 123 is converted and displayed from scratch.
REQ-039 score held constant for 1000 cycles -> busy stays 0 and the digit registers never change.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score seven-segment display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
//
// state | meaning
// IDLE  | waiting for start, captures bin when it arrives
// LOAD  | clears accumulator, arms iteration count
// SHIFT | one adjust+shift per clk, 8 iterations
// DONE  | result valid on bcd, done high for this cycle
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state;
  logic [7:0]  sr;
  logic [3:0]  cnt;
  logic [11:0] adj;

  assign adj = {bcd_adjust(bcd[11:8]), bcd_adjust(bcd[7:4]), bcd_adjust(bcd[3:0])};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= bin;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          bcd   <= '0;
          cnt   <= 4'd8;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sr} <= {adj, sr} << 1;
          cnt       <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_seg_display.sv
// Score display: change detect, BCD conversion, 3-digit multiplexed scan.
// Define SCORE_LZB_EN to blank leading zeros on tens and hundreds.
module score_seg_display
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] score,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [7:0]    shown_score;
  logic [7:0]    captured;
  logic          start;
  logic          done;
  logic          upd;
  logic [11:0]   bcd;
  logic [11:0]   digits;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    slot;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign start = (score != shown_score);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (score),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // shown_score moves during DONE so the following IDLE cycle compares
  // against the new value; digits follow one clk later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_score <= '0;
      captured    <= '0;
      upd         <= 1'b0;
      digits      <= '0;
    end else begin
      if (!busy && start) captured <= score;
      if (done) shown_score <= captured;
      upd <= done;
      if (upd) digits <= bcd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      slot     <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      slot     <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nib    = 4'hF;
    an_nxt = 4'b1111;
    case (slot)
      2'd0: begin nib = digits[3:0];  an_nxt = 4'b1110; end
      2'd1: begin nib = digits[7:4];  an_nxt = 4'b1101; end
      2'd2: begin nib = digits[11:8]; an_nxt = 4'b1011; end
      default: begin nib = 4'hF; an_nxt = 4'b1111; end
    endcase
    seg_nxt = seg_encode(nib);
`ifdef SCORE_LZB_EN
    if (slot == 2'd2 && digits[11:8] == 4'd0) seg_nxt = SEG_BLANK;
    if (slot == 2'd1 && digits[11:4] == 8'd0) seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_score_seg_display.sv
// Directed bench for score_seg_display with a short scan period.
module tb_score_seg_display;

`ifdef SCORE_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] score = 8'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;

  score_seg_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .score (score),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic show_check(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (an !== an_exp && n < 16);
    chk({tag, "_an"}, an, an_exp);
    chk({tag, "_seg"}, seg, seg_exp);
  endtask

  task automatic display_check(input string tag, input int h, input int t, input int u);
    show_check({tag, "_units"}, 4'b1110, seg_of(u));
    show_check({tag, "_tens"}, 4'b1101, (LZB && h == 0 && t == 0) ? 7'h7F : seg_of(t));
    show_check({tag, "_hund"}, 4'b1011, (LZB && h == 0) ? 7'h7F : seg_of(h));
  endtask

  // Busy must span 10 cycles; digits unchanged after 10 edges, new after 11.
  task automatic convert_check(input string tag, input logic [7:0] s,
                               input logic [11:0] old_d, input logic [11:0] new_d);
    int busy_cycles = 0;
    score = s;
    for (int i = 0; i <= 11; i++) begin
      tick(1);
      if (busy) busy_cycles++;
      if (i == 0) chk({tag, "_busy_rise"}, busy, 1'b1);
      if (i == 10) chk({tag, "_digits_pre"}, dut.digits, old_d);
      if (i == 11) chk({tag, "_digits_post"}, dut.digits, new_d);
    end
    chk({tag, "_busy_len"}, busy_cycles, 10);
  endtask

  initial begin
    int gap;
    int busy_seen;
    int changes;
    logic [1:0] sl;
    logic [3:0] an_e;

    // reset held
    tick(3);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_busy", busy, 1'b0);
    chk("rst_digits", dut.digits, 12'h000);

    // release with score 0: scan sequence, 4 clk per slot
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      sl = 2'((k - 1) / 4);
      an_e = (sl == 2'd0) ? 4'b1110 : (sl == 2'd1) ? 4'b1101 : 4'b1011;
      chk($sformatf("scan_an_%0d", k), an, an_e);
      chk($sformatf("scan_seg_%0d", k), seg,
          (sl == 2'd0 || !LZB) ? 7'b1000000 : 7'b1111111);
      chk($sformatf("scan_busy_%0d", k), busy, 1'b0);
    end
    tick(1);
    chk("scan_wrap_an", an, 4'b1110);

    convert_check("c255", 8'd255, 12'h000, 12'h255);
    display_check("d255", 2, 5, 5);

    convert_check("c99", 8'd99, 12'h255, 12'h099);
    convert_check("c100", 8'd100, 12'h099, 12'h100);
    display_check("d100", 1, 0, 0);

    convert_check("c7", 8'd7, 12'h100, 12'h007);
    display_check("d7", 0, 0, 7);

    // 7->8, then 9 arrives during the third SHIFT cycle
    score = 8'd8;
    gap = 0;
    for (int i = 0; i <= 22; i++) begin
      tick(1);
      if (i == 3) score = 8'd9;
      if (i >= 1 && i <= 20 && !busy) gap++;
      if (i == 10) begin
        chk("mid_gap_busy", busy, 1'b0);
        chk("mid_first_pre", dut.digits, 12'h007);
      end
      if (i == 11) begin
        chk("mid_second_start", busy, 1'b1);
        chk("mid_first_post", dut.digits, 12'h008);
      end
      if (i == 21) chk("mid_second_pre", dut.digits, 12'h008);
      if (i == 22) chk("mid_second_post", dut.digits, 12'h009);
    end
    chk("mid_gap_len", gap, 1);
    display_check("d9", 0, 0, 9);

    // reset pulse while converting 123
    score = 8'd123;
    tick(5);
    chk("abort_in_shift_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_an", an, 4'b1111);
    chk("abort_seg", seg, 7'h7F);
    chk("abort_digits", dut.digits, 12'h000);
    tick(2);
    chk("abort_hold_digits", dut.digits, 12'h000);
    chk("abort_hold_an", an, 4'b1111);
    rst = 1'b1;
    convert_check("c123", 8'd123, 12'h000, 12'h123);
    display_check("d123", 1, 2, 3);

    // score held constant
    busy_seen = 0;
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (busy) busy_seen++;
      if (dut.digits !== 12'h123) changes++;
    end
    chk("hold_busy", busy_seen, 0);
    chk("hold_digits", changes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
